traffic_light_sequencer: RTL



---
 rtl/traffic_light_pkg.sv | 23 ++
 rtl/phase_timer.sv | 25 ++
 rtl/traffic_light_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/traffic_light_pkg.sv
// Phase encoding shared with the traffic light decode FSM, plus default phase durations.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    PH_RED     = 2'b00,
    PH_RED_YEL = 2'b01,
    PH_GREEN   = 2'b10,
    PH_YEL     = 2'b11
  } phase_t;

  localparam int DEF_RED_CYCLES       = 16;
  localparam int DEF_RED_YEL_CYCLES   = 4;
  localparam int DEF_GREEN_CYCLES     = 20;
  localparam int DEF_MIN_GREEN_CYCLES = 8;
  localparam int DEF_YEL_CYCLES       = 4;
  localparam int DEF_CNT_W            = 8;

  // The encoding is a plain 2-bit ring, so the successor is an increment.
  function automatic phase_t next_phase(input phase_t p);
    return phase_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase duration counter: counts enabled cycles, flags the last cycle and the minimum point.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] dur,
  input  logic [CNT_W-1:0] min_cnt,
  output logic             expire,
  output logic             at_min
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)   cnt <= '0;
    else if (en) cnt <= clr ? '0 : cnt + 1'b1;
  end

  assign expire = (cnt == dur - 1'b1);
  assign at_min = (cnt >= min_cnt - 1'b1);

endmodule

// File: rtl/traffic_light_sequencer.sv
// Timed RED -> RED_YEL -> GREEN -> YELLOW generator with pedestrian early exit.
// Define NIGHT_MODE_EN to add the night_mode input and the flashing-yellow NIGHT state.
module traffic_light_sequencer
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES       = DEF_RED_CYCLES,
  parameter int RED_YEL_CYCLES   = DEF_RED_YEL_CYCLES,
  parameter int GREEN_CYCLES     = DEF_GREEN_CYCLES,
  parameter int MIN_GREEN_CYCLES = DEF_MIN_GREEN_CYCLES,
  parameter int YEL_CYCLES       = DEF_YEL_CYCLES,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic   clk,
  input  logic   rstb,
  input  logic   enable,
  input  logic   ped_req,
`ifdef NIGHT_MODE_EN
  input  logic   night_mode,
`endif
  output logic   ped_ack,
  output logic   code_a,
  output logic   code_b,
  output phase_t phase,
  output logic   phase_done
);

  phase_t           st_q, st_d;
  logic [1:0]       code_q, code_d;
  logic             night_q, night_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             adv, expire, at_min, night_req;
  logic [CNT_W-1:0] dur;

`ifdef NIGHT_MODE_EN
  assign night_req = night_mode;
`else
  assign night_req = 1'b0;
`endif

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rstb    (rstb),
    .en      (enable),
    .clr     (adv),
    .dur     (dur),
    .min_cnt (CNT_W'(MIN_GREEN_CYCLES)),
    .expire  (expire),
    .at_min  (at_min)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      st_q    <= PH_RED;
      code_q  <= 2'b00;
      night_q <= 1'b0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      code_q  <= code_d;
      night_q <= night_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    code_d  = code_q;
    night_d = night_q;
    pend_d  = pend_q | ped_req;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    adv     = 1'b0;
    unique case (st_q)
      PH_RED:     dur = CNT_W'(RED_CYCLES);
      PH_RED_YEL: dur = CNT_W'(RED_YEL_CYCLES);
      PH_GREEN:   dur = CNT_W'(GREEN_CYCLES);
      default:    dur = CNT_W'(YEL_CYCLES);
    endcase
    if (night_q) dur = CNT_W'(YEL_CYCLES);

    if (enable) begin
      if (night_q) begin
        // Leaving night restarts a full RED; pedestrian state is carried untouched.
        if (!night_req) begin
          night_d = 1'b0;
          st_d    = PH_RED;
          code_d  = 2'b00;
          adv     = 1'b1;
          done_d  = 1'b1;
        end else if (expire) begin
          code_d = ~code_q;
          adv    = 1'b1;
          done_d = 1'b1;
        end
      end else begin
        adv = expire | ((st_q == PH_GREEN) & pend_q & at_min);
        if (adv) begin
          done_d = 1'b1;
          if (night_req) begin
            night_d = 1'b1;
            code_d  = 2'b11;
          end else begin
            st_d   = next_phase(st_q);
            code_d = next_phase(st_q);
            // A request arriving on the serving edge survives for the next GREEN.
            if (next_phase(st_q) == PH_RED && pend_q) begin
              ack_d  = 1'b1;
              pend_d = ped_req;
            end
          end
        end
      end
    end
  end

  assign code_a     = code_q[1];
  assign code_b     = code_q[0];
  assign phase      = phase_t'(code_q);
  assign ped_ack    = ack_q;
  assign phase_done = done_q;

endmodule
